gray_step_ctrl: RTL

GRAY_STEP_CTRL -- requirements
Module: gray_step_ctrl

---
 rtl/gray_step_ctrl_pkg.sv | 13 +
 rtl/gray_step_ctrl_gray_conv3.sv | 9 +
 rtl/gray_step_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/gray_step_ctrl_pkg.sv
// Shared constants for the Gray-coded step controller: FSM encodings and dwell default.
package gray_step_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_STEP = 2'b01,
      ST_HOLD = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   localparam int unsigned DWELL_DEFAULT = 4;

endpackage

// File: rtl/gray_step_ctrl_gray_conv3.sv
// Three-bit binary to reflected Gray code conversion, purely combinational.
module gray_conv3 (
   input  logic [2:0] bin,
   output logic [2:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_step_ctrl.sv
// Step sequencer: moves a 3-bit position by +/-1 per step, holding each step for DWELL
// cycles, and publishes the position in Gray code so observers only ever see one bit flip.
module gray_step_ctrl
   import gray_step_ctrl_pkg::*;
#(
   parameter int unsigned DWELL = DWELL_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dir,
   input  logic [2:0] steps,
   input  logic       stop,
   output logic       ack,
   output logic       busy,
   output logic       done,
   output logic [2:0] pos,
   output logic [2:0] G
);

   state_e     state_q, state_d;
   logic [2:0] pos_q, pos_d;
   logic [2:0] remaining_q, remaining_d;
   logic [3:0] dwell_q, dwell_d;
   logic       dir_q, dir_d;
   logic       ack_q, ack_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      pos_d       = pos_q;
      remaining_d = remaining_q;
      dwell_d     = dwell_q;
      dir_d       = dir_q;
      ack_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               ack_d       = 1'b1;
               dir_d       = dir;
               remaining_d = steps;
               state_d     = (steps != 3'd0) ? ST_STEP : ST_DONE;
            end
         end
         ST_STEP: begin
            if (stop) begin
               state_d = ST_DONE;
            end else begin
               pos_d       = dir_q ? pos_q + 3'd1 : pos_q - 3'd1;
               remaining_d = remaining_q - 3'd1;
               dwell_d     = 4'(DWELL - 1);
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d = ST_DONE;
            end else if (dwell_q == 4'd0) begin
               state_d = (remaining_q != 3'd0) ? ST_STEP : ST_DONE;
            end else begin
               dwell_d = dwell_q - 4'd1;
            end
         end
         ST_DONE: begin
            // Entered straight from IDLE (steps=0) the pulse is deferred one cycle so it
            // never coincides with ack; otherwise it fires on entry.
            state_d = done_q ? ST_IDLE : ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_q != ST_IDLE) && (state_d == ST_DONE) && !done_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_IDLE;
         pos_q       <= 3'd0;
         remaining_q <= 3'd0;
         dwell_q     <= 4'd0;
         dir_q       <= 1'b0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         remaining_q <= remaining_d;
         dwell_q     <= dwell_d;
         dir_q       <= dir_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ack  = ack_q;
   assign busy = busy_q;
   assign done = done_q;
   assign pos  = pos_q;

   gray_conv3 u_gray_conv3 (
      .bin  (pos_q),
      .gray (G)
   );

endmodule
